// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of a multi-cycle, non-pipelined RV32I core. It holds the program
// counter and fetches one instruction word at a time from instruction memory
// over a req/ack handshake. The word is registered onto `inst` for the control
// unit and the register file. When the instruction is allowed to advance, the
// PC moves to pc+4 or to the word-aligned ALU redirect target, and the
// retired-instruction counter increments.
//
// Two-state FSM:
//   FETCH : request held on imem_req/imem_addr until imem_ack.
//   ISSUE : instruction live on inst/inst_valid until stall drops.
//
// Ports
//   clk         in   core clock, rising edge
//   reset       in   synchronous active-low reset
//   PCSel       in   1 = next PC from alu_result, 0 = pc+4
//   alu_result  in   [31:0] redirect target (bits [1:0] ignored)
//   stall       in   hold the current instruction in ISSUE
//   imem_req    out  instruction memory request
//   imem_addr   out  [31:0] request address (equals pc)
//   imem_ack    in   memory response; imem_rdata valid this cycle
//   imem_rdata  in   [31:0] instruction word from memory
//   inst        out  [31:0] registered instruction word
//   inst_valid  out  inst/pc describe a live instruction
//   pc          out  [31:0] PC of the instruction being fetched or issued
//   pc_plus4    out  [31:0] pc + 4 (mod 2^32), used for link write-back
//   instret     out  [31:0] instructions retired since reset (mod 2^32)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSel,
  input  logic [31:0] alu_result,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state;

  // Redirect targets are forced onto a word boundary. This also performs the
  // JALR low-bit clear; misalignment is not trapped here.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // imem_req and inst_valid are registered alongside the state. imem_req is
  // still 0 in the first FETCH cycle after reset, so a request is raised only
  // in the cycle after reset is sampled high. An ack only counts while a
  // request is actually outstanding, which keeps stray acks out of inst.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      instret    <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            inst       <= imem_rdata;
            state      <= ISSUE;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc         <= PCSel ? align_word(alu_result) : pc_plus4;
            instret    <= instret + 32'd1;
            state      <= FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSel;
  logic [31:0] alu_result;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instret;

  int tests  = 0;
  int failed = 0;

  instruction_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .PCSel      (PCSel),
    .alu_result (alu_result),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    PCSel      = 1'b0;
    alu_result = 32'h0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_req",     {31'b0, imem_req},   32'd0);
    chk("rst_valid",   {31'b0, inst_valid}, 32'd0);
    chk("rst_pc",      pc,                  32'h0);
    chk("rst_inst",    inst,                32'h0000_0013);
    chk("rst_instret", instret,             32'd0);

    // Zero-wait memory, sequential fetch 0,4,8,12
    reset = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("zw_req",     {31'b0, imem_req},   32'd1);
      chk("zw_addr",    imem_addr,           32'(4 * k));
      chk("zw_valid0",  {31'b0, inst_valid}, 32'd0);
      chk("zw_instret", instret,             32'(k));
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0013;
      tick();
      imem_ack = 1'b0;
      chk("zw_valid1",  {31'b0, inst_valid}, 32'd1);
      chk("zw_inst",    inst,                32'h0000_0013);
      chk("zw_req_iss", {31'b0, imem_req},   32'd0);
      chk("zw_pcp4",    pc_plus4,            32'(4 * k + 4));
      tick();
    end
    chk("zw_req3",     {31'b0, imem_req}, 32'd1);
    chk("zw_addr3",    imem_addr,         32'd12);
    chk("zw_instret3", instret,           32'd3);

    // Re-reset, then delayed ack (3 wait cycles) at address 0
    reset = 1'b0;
    tick();
    chk("rr_req",     {31'b0, imem_req}, 32'd0);
    chk("rr_pc",      pc,                32'h0);
    chk("rr_instret", instret,           32'd0);
    reset = 1'b1;
    tick();
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk("dl_req",   {31'b0, imem_req},   32'd1);
      chk("dl_addr",  imem_addr,           32'h0);
      chk("dl_valid", {31'b0, inst_valid}, 32'd0);
      imem_ack = (i == 3);
      tick();
    end
    imem_ack = 1'b0;
    chk("dl_valid1", {31'b0, inst_valid}, 32'd1);
    chk("dl_inst",   inst,                32'hDEAD_BEEF);

    // Stall for 5 cycles in ISSUE with a spurious ack and ignored redirect
    stall      = 1'b1;
    PCSel      = 1'b1;
    alu_result = 32'h0000_0777;
    for (int i = 0; i < 5; i++) begin
      imem_ack   = (i == 2);
      imem_rdata = 32'h1234_5678;
      tick();
      chk("st_inst",    inst,                32'hDEAD_BEEF);
      chk("st_pc",      pc,                  32'h0);
      chk("st_instret", instret,             32'd0);
      chk("st_req",     {31'b0, imem_req},   32'd0);
      chk("st_valid",   {31'b0, inst_valid}, 32'd1);
    end
    imem_ack = 1'b0;

    // Redirect with unaligned target 0x103 -> 0x100
    stall      = 1'b0;
    PCSel      = 1'b1;
    alu_result = 32'h0000_0103;
    tick();
    chk("rd_req",     {31'b0, imem_req}, 32'd1);
    chk("rd_addr",    imem_addr,         32'h0000_0100);
    chk("rd_instret", instret,           32'd1);
    PCSel      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0;
    chk("rd_inst",  inst,     32'h0050_0093);
    chk("rd_pcp4",  pc_plus4, 32'h0000_0104);

    // Redirect to 0x40, then reset during FETCH with an ack present
    PCSel      = 1'b1;
    alu_result = 32'h0000_0041;
    tick();
    chk("f40_addr",    imem_addr, 32'h0000_0040);
    chk("f40_instret", instret,   32'd2);
    PCSel    = 1'b0;
    reset    = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("mr_req",     {31'b0, imem_req},   32'd0);
    chk("mr_valid",   {31'b0, inst_valid}, 32'd0);
    chk("mr_pc",      pc,                  32'h0);
    chk("mr_inst",    inst,                32'h0000_0013);
    chk("mr_instret", instret,             32'd0);

    // PC wrap: redirect to 0xFFFF_FFFC, then sequential advance to 0
    reset = 1'b1;
    tick();
    chk("wr_req0", {31'b0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    imem_ack   = 1'b0;
    PCSel      = 1'b1;
    alu_result = 32'hFFFF_FFFF;
    tick();
    chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    PCSel    = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("wr_pcp4", pc_plus4, 32'h0000_0000);
    tick();
    chk("wr_addr0",   imem_addr, 32'h0000_0000);
    chk("wr_instret", instret,   32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
